palette_ram_arbiter: RTL and testbench

//  Shares one single-port 64x15 custom-palette BRAM between the video pixel lookup
//  and the HPS loader (ioctl) that downloads a user palette file.

---
 rtl/palette_ram_arbiter.sv | 157 +++++++++++++++
 tb/tb_palette_ram_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/palette_ram_arbiter.sv
// Shares a single-port 64x15 palette BRAM between video pixel lookups and the
// HPS palette loader. Video reads own their slot; loader words fill idle slots.
module palette_ram_arbiter #(
    parameter int ENTRIES = 64,
    parameter int IDX_W   = 6,
    parameter int DW      = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pix_ce_n,
    input  logic [IDX_W-1:0]  color,
    output logic [DW-1:0]     pixel,
    input  logic              ioctl_download,
    input  logic              ioctl_wr,
    input  logic [IDX_W:0]    ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    output logic              ioctl_wait,
    output logic [IDX_W-1:0]  ram_addr,
    output logic              ram_we,
    output logic [DW-1:0]     ram_din,
    input  logic [DW-1:0]     ram_dout,
    output logic              pal_valid,
    output logic              load_err
);

    localparam logic [IDX_W:0] FULL_CNT = (IDX_W+1)'(ENTRIES);

    typedef enum logic [1:0] {IDLE, LOAD, FLUSH} state_t;

    state_t state, state_nxt;

    logic             dl_q, pix_q, start_req;
    logic [7:0]       lo;
    logic [IDX_W-1:0] lo_idx;
    logic             lo_v;
    logic [DW-1:0]    pend_data, skid_data;
    logic [IDX_W-1:0] pend_idx, skid_idx;
    logic             pend_v, skid_v;
    logic [IDX_W:0]   wcnt;

    logic             load_active, start_load, flush_done;
    logic             dl_rise, dl_fall;
    logic             byte_in, idx_match, word_ok;
    logic             write_slot;
    logic             pend_take_skid, pend_take_word, skid_take_word;
    logic [DW-1:0]    new_word;
    logic [IDX_W-1:0] byte_idx;
    logic             unused_dout_msb;

    assign dl_rise  = ioctl_download & ~dl_q;
    assign dl_fall  = ~ioctl_download & dl_q;
    assign byte_idx = ioctl_addr[IDX_W:1];
    assign new_word = {ioctl_dout[DW-9:0], lo};
    assign unused_dout_msb = ioctl_dout[7];

    assign byte_in   = ioctl_wr & load_active;
    assign idx_match = lo_v && (lo_idx == byte_idx);
    assign word_ok   = byte_in & ioctl_addr[0] & idx_match;

    // The read slot and the cycle its data is on ram_dout are both off-limits.
    assign write_slot = pend_v & ~pix_ce_n & ~pix_q & ~reset;

    assign pend_take_skid = write_slot & skid_v;
    assign pend_take_word = word_ok & (write_slot ? ~skid_v : ~pend_v);
    assign skid_take_word = word_ok & (write_slot ? skid_v : (pend_v & ~skid_v));

    assign ram_we   = write_slot;
    assign ram_addr = pix_ce_n ? color : (write_slot ? pend_idx : '0);
    assign ram_din  = pend_data;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        // NOTE: default first so every path assigns state_nxt and no latch is inferred.
        state_nxt = state;
        case (state)
            IDLE:    if (dl_rise || (start_req && ioctl_download)) state_nxt = LOAD;
            LOAD:    if (dl_fall) state_nxt = FLUSH;
            FLUSH:   if (!pend_v && !skid_v) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        load_active = (state == LOAD);
        start_load  = (state == IDLE)  && (state_nxt == LOAD);
        flush_done  = (state == FLUSH) && (state_nxt == IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pixel      <= '0;
            ioctl_wait <= 1'b0;
            pal_valid  <= 1'b0;
            load_err   <= 1'b0;
            pend_v     <= 1'b0;
            skid_v     <= 1'b0;
            lo_v       <= 1'b0;
            wcnt       <= '0;
            dl_q       <= 1'b0;
            pix_q      <= 1'b0;
            start_req  <= 1'b0;
        end else begin
            dl_q       <= ioctl_download;
            pix_q      <= pix_ce_n;
            ioctl_wait <= pend_v | skid_v;

            if (pix_q) pixel <= ram_dout;

            // A session requested during FLUSH is remembered until IDLE can take it.
            if (start_load || !ioctl_download) start_req <= 1'b0;
            else if (dl_rise && state != IDLE) start_req <= 1'b1;

            if (start_load) begin
                pal_valid <= 1'b0;
                load_err  <= 1'b0;
                wcnt      <= '0;
                lo_v      <= 1'b0;
            end else begin
                if (write_slot && wcnt != FULL_CNT) wcnt <= wcnt + 1'b1;
                if (byte_in) begin
                    if (!ioctl_addr[0])  lo_v     <= 1'b1;
                    else if (idx_match)  lo_v     <= 1'b0;
                    else                 load_err <= 1'b1;
                end
            end

            if (flush_done) pal_valid <= (wcnt == FULL_CNT) && !load_err;

            pend_v <= (write_slot ? skid_v : pend_v) | pend_take_word;
            skid_v <= (skid_v & ~write_slot) | skid_take_word;
        end
    end

    // NOTE: payload registers carry no reset; their valid flags alone decide use.
    always_ff @(posedge clk) begin
        if (byte_in && !ioctl_addr[0]) begin
            lo     <= ioctl_dout;
            lo_idx <= byte_idx;
        end
        if (pend_take_skid) begin
            pend_data <= skid_data;
            pend_idx  <= skid_idx;
        end else if (pend_take_word) begin
            pend_data <= new_word;
            pend_idx  <= byte_idx;
        end
        if (skid_take_word) begin
            skid_data <= new_word;
            skid_idx  <= byte_idx;
        end
    end

endmodule

// File: tb/tb_palette_ram_arbiter.sv
// Directed bench for palette_ram_arbiter with a behavioural single-port BRAM.
module tb_palette_ram_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        pix_ce_n;
    logic [5:0]  color;
    logic [14:0] pixel;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [6:0]  ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        ioctl_wait;
    logic [5:0]  ram_addr;
    logic        ram_we;
    logic [14:0] ram_din;
    logic [14:0] ram_dout;
    logic        pal_valid;
    logic        load_err;

    palette_ram_arbiter dut (
        .clk(clk), .reset(reset), .pix_ce_n(pix_ce_n), .color(color), .pixel(pixel),
        .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
        .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait), .ram_addr(ram_addr),
        .ram_we(ram_we), .ram_din(ram_din), .ram_dout(ram_dout),
        .pal_valid(pal_valid), .load_err(load_err)
    );

    always #5 clk = ~clk;

    // BRAM model with write logging and slot-rule monitoring
    logic [14:0] mem [64];
    logic        pre_we = 1'b0;
    logic [5:0]  pre_addr = '0;
    logic [14:0] pre_data = '0;
    logic        pix_prev = 1'b0;
    int          nwrites = 0;
    int          nviol = 0;
    logic [5:0]  wlog_addr [$];
    logic [14:0] wlog_data [$];

    always @(posedge clk) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        else if (ram_we) begin
            mem[ram_addr] <= ram_din;
            wlog_addr.push_back(ram_addr);
            wlog_data.push_back(ram_din);
            nwrites <= nwrites + 1;
            if (pix_ce_n || pix_prev) nviol <= nviol + 1;
        end
        ram_dout <= ram_we ? 15'h0 : mem[ram_addr];
        pix_prev <= pix_ce_n;
    end

    int checks = 0;
    int errors = 0;
    bit pix_auto = 1'b0;
    int phase = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (pix_auto) begin
            pix_ce_n = (phase == 0);
            phase = (phase + 1) % 4;
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send_byte(input logic [6:0] a, input logic [7:0] d, input bit honor);
        int n;
        n = 0;
        while (honor && ioctl_wait) begin
            ioctl_wr = 1'b0;
            tick();
            n++;
            if (n >= 64) begin
                check("wait_timeout", 32'(ioctl_wait), 32'h0);
                break;
            end
        end
        ioctl_wr   = 1'b1;
        ioctl_addr = a;
        ioctl_dout = d;
        tick();
    endtask

    task automatic start_session();
        ioctl_download = 1'b1;
        ticks(3);
    endtask

    task automatic end_session();
        ioctl_wr = 1'b0;
        ioctl_download = 1'b0;
        ticks(12);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int base;
        int qbase;
        int bad;
        logic [14:0] exp_w;

        reset = 1'b1;
        pix_ce_n = 1'b0;
        color = 6'd5;
        ioctl_download = 1'b0;
        ioctl_wr = 1'b0;
        ioctl_addr = '0;
        ioctl_dout = '0;
        ticks(3);
        check("rst_pixel",     32'(pixel),      32'h0);
        check("rst_wait",      32'(ioctl_wait), 32'h0);
        check("rst_we",        32'(ram_we),     32'h0);
        check("rst_addr",      32'(ram_addr),   32'h0);
        check("rst_pal_valid", 32'(pal_valid),  32'h0);
        check("rst_load_err",  32'(load_err),   32'h0);
        reset = 1'b0;

        pre_we = 1'b1; pre_addr = 6'd5; pre_data = 15'h1234;
        tick();
        pre_addr = 6'd9; pre_data = 15'h0abc;
        tick();
        pre_we = 1'b0;
        tick();

        // 1: video lookups only
        for (int i = 0; i < 4; i++) begin
            color = (i == 2) ? 6'd9 : 6'd5;
            pix_ce_n = 1'b1;
            tick();
            pix_ce_n = 1'b0;
            tick();
            check("pixel_lookup", 32'(pixel), (i == 2) ? 32'h0abc : 32'h1234);
            ticks(2);
        end
        check("pixel_hold", 32'(pixel), 32'h1234);
        check("no_write_idle", 32'(nwrites), 32'h0);

        // 2: full download with video running
        color = 6'd5;
        pix_auto = 1'b1;
        start_session();
        base = nwrites;
        for (int k = 0; k < 64; k++) begin
            send_byte(7'(2*k), 8'(k), 1'b1);
            send_byte(7'(2*k+1), 8'(8'h40 | k), 1'b1);
        end
        end_session();
        bad = 0;
        for (int k = 0; k < 64; k++) begin
            exp_w = 15'(16'h4000 | (k << 8) | k);
            if (mem[k] !== exp_w) bad++;
        end
        check("bram_contents", 32'(bad), 32'h0);
        check("full_writes", 32'(nwrites - base), 32'd64);
        check("slot_rule", 32'(nviol), 32'h0);
        check("pal_valid_full", 32'(pal_valid), 32'h1);
        check("pixel_after_load", 32'(pixel), 32'h4505);

        // 3: skid register under a blocked slot
        pix_auto = 1'b0;
        pix_ce_n = 1'b0;
        start_session();
        check("pal_clear_on_start", 32'(pal_valid), 32'h0);
        base = nwrites;
        qbase = wlog_addr.size();
        send_byte(7'd0, 8'h11, 1'b0);
        send_byte(7'd1, 8'h22, 1'b0);
        pix_ce_n = 1'b1;
        send_byte(7'd2, 8'h33, 1'b0);
        pix_ce_n = 1'b0;
        check("wait_skid", 32'(ioctl_wait), 32'h1);
        send_byte(7'd3, 8'h44, 1'b0);
        ioctl_wr = 1'b0;
        check("skid_we0",   32'(ram_we),   32'h1);
        check("skid_addr0", 32'(ram_addr), 32'h0);
        check("skid_din0",  32'(ram_din),  32'h2211);
        tick();
        check("skid_we1",   32'(ram_we),   32'h1);
        check("skid_addr1", 32'(ram_addr), 32'h1);
        check("skid_din1",  32'(ram_din),  32'h4433);
        ticks(3);
        check("wait_release", 32'(ioctl_wait), 32'h0);
        check("skid_writes", 32'(nwrites - base), 32'd2);
        if (wlog_addr.size() >= qbase + 2) begin
            check("skid_log0", 32'(wlog_data[qbase]),   32'h2211);
            check("skid_log1", 32'(wlog_data[qbase+1]), 32'h4433);
        end else begin
            check("skid_log_len", 32'(wlog_addr.size() - qbase), 32'd2);
        end
        end_session();
        check("pal_valid_partial", 32'(pal_valid), 32'h0);

        // 4: odd byte without its even partner
        start_session();
        base = nwrites;
        send_byte(7'd3, 8'h55, 1'b1);
        ioctl_wr = 1'b0;
        check("load_err_set", 32'(load_err), 32'h1);
        ticks(3);
        check("err_no_write", 32'(nwrites - base), 32'h0);
        end_session();
        check("pal_valid_err", 32'(pal_valid), 32'h0);
        check("load_err_sticky", 32'(load_err), 32'h1);

        // 5: short file of 100 bytes
        pix_auto = 1'b1;
        start_session();
        check("load_err_clear", 32'(load_err), 32'h0);
        base = nwrites;
        for (int k = 0; k < 50; k++) begin
            send_byte(7'(2*k), 8'(k ^ 8'h15), 1'b1);
            send_byte(7'(2*k+1), 8'(k), 1'b1);
        end
        end_session();
        check("short_writes", 32'(nwrites - base), 32'd50);
        check("pal_valid_short", 32'(pal_valid), 32'h0);
        check("short_slot_rule", 32'(nviol), 32'h0);

        // 6: reset while a word is pending
        pix_auto = 1'b0;
        pix_ce_n = 1'b0;
        start_session();
        base = nwrites;
        send_byte(7'd0, 8'h01, 1'b0);
        pix_ce_n = 1'b1;
        send_byte(7'd1, 8'h02, 1'b0);
        ioctl_wr = 1'b0;
        pix_ce_n = 1'b0;
        tick();
        pix_ce_n = 1'b1;
        check("wait_before_rst", 32'(ioctl_wait), 32'h1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        pix_ce_n = 1'b0;
        check("rst_mid_we",        32'(ram_we),     32'h0);
        check("rst_mid_wait",      32'(ioctl_wait), 32'h0);
        check("rst_mid_pal_valid", 32'(pal_valid),  32'h0);
        ticks(4);
        check("rst_mid_no_write", 32'(nwrites - base), 32'h0);
        end_session();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
